uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver; counterpart of uart_tx on the same serial line.
// - Oversamples the async rx line, recovers 8N1-style frames: start, WIDTH data bits LSB-first, optional parity, stop.
// - Hands each received word to the consumer through a one-entry valid/ready buffer.
// - Sits between the board rx pin and the receive-side buffer/FIFO of buff_uart.
// PARAMETERS
// - CLOCK_FREQ  100_000_000  clock frequency in Hz.
// - BAUD_RATE   115_200      line bit rate in bits/s.
// - WIDTH       8            data bits per frame, 5..9.
// - TICKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (localparam, truncated); elaboration error if < 4.
// PORTS
// - clock           in   1      system clock, all logic on posedge.
// - reset           in   1      synchronous, active-high reset.
// - rx              in   1      async serial line, idle high.
// - data            out  WIDTH  received word; stable while valid=1.
// - valid           out  1      data holds an unconsumed word.
// - ready           in   1      consumer accepts data on a cycle with valid&&ready.
// - framing_error   out  1      1-cycle pulse: stop bit sampled 0.
// - overrun         out  1      1-cycle pulse: word completed while buffer full; new word dropped.
// BEHAVIOUR
// - Sync: rx passes a 2-FF synchronizer (rx_s), reset value 1; all decisions use rx_s only.
// - Reset: state=IDLE, tick counter=0, bit index=0, data=0, valid=0, framing_error=0, overrun=0, sync FFs=1.
// - Reset mid-frame: the partial frame is discarded; buffered word is lost.
// - Tick counter: counts down; an action fires when it reaches 0, then reloads.
// - States and transitions:
//   - IDLE: rx_s==0 -> START, counter=TICKS_PER_BIT/2-1.
//   - START: at action, rx_s==0 -> DATA, counter=TICKS_PER_BIT-1, bit index=0; rx_s==1 -> glitch, back to IDLE, no pulse.
//   - DATA: at action, shift in rx_s at bit index (LSB first); after bit WIDTH-1 -> PARITY if enabled else STOP.
//   - PARITY: see CONFIGURATION; then -> STOP.
//   - STOP: at action (mid stop bit):
//     - rx_s==1 -> deliver word, -> IDLE.
//     - rx_s==0 -> framing_error pulse, word dropped, -> BREAK.
//   - BREAK: wait for rx_s==1, then -> IDLE. A long low line yields exactly one framing_error.
//   - Any illegal encoding -> IDLE.
// - Sampling: every sample lands at bit centre +/-1 clock (counter reloads TICKS_PER_BIT-1 each bit).
// - Latency: valid rises the cycle after the stop-bit sample, i.e. ~(WIDTH+1.5)*TICKS_PER_BIT+3 clocks after the start-bit falling edge on rx.
// - Next frame: returning to IDLE at mid stop bit allows back-to-back frames with a one-bit stop.
// - Handshake: data/valid are registered outputs.
//   - valid&&ready clears valid next cycle.
//   - valid must not drop without ready; data must not change while valid.
// - Deliver with valid=0, or with valid&&ready in the same cycle: data loads the new word, valid=1, no overrun.
// - Deliver with valid&&!ready: old word kept, overrun pulses 1 cycle.
// - Pulses: framing_error and overrun are high for exactly one clock per event.
// CONFIGURATION
// - `UART_RX_PARITY_EN defined:
//   - PARITY state samples one even-parity bit after the data bits.
//   - Mismatch: word dropped; framing_error pulses at the stop sample, regardless of stop value.
//   - Stop bit still required before IDLE.
//   - Frame length is WIDTH+3 bits.
// - `UART_RX_PARITY_EN undefined: no PARITY state, no parity logic; frame length is WIDTH+2 bits.
// TESTING (CLOCK_FREQ=1_600, BAUD_RATE=100 -> TICKS_PER_BIT=16, WIDTH=8, parity off unless stated)
// - Single frame 0xA5, ready=1: valid pulses 1 clock with data=0xA5; framing_error=overrun=0.
// - Frames 0x00, 0xFF, 0x3C back-to-back, one stop bit each, ready=1: three valid pulses in order with the same values.
// - Glitch: rx low for 4 clocks then high: no valid, no error pulse; state returns to IDLE.
// - Frame 0x55 with stop bit forced 0, rx then held low 100 clocks: exactly one framing_error, valid stays 0.
//   Next good frame 0x12 is received correctly.
// - ready=0, frames 0x11 then 0x22: valid=1 with data=0x11, overrun pulses once, data stays 0x11.
//   Raise ready: valid clears next cycle.
// - reset held 1 clock mid-data-bit of frame 0x77: all outputs 0, no valid for that frame.
//   Following frame 0x81 is received correctly.
// - With `UART_RX_PARITY_EN: 0x03 with parity 0 -> valid, data=0x03; 0x03 with parity 1 -> framing_error, no valid.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side word handshake between uart_rx (master) and its consumer (slave).
// valid/ready: a word transfers on a cycle with valid && ready; valid holds and data stays put until then.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, WIDTH data bits LSB-first, optional even parity, stop.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    uart_rx_if.master   out_if,
    output logic        framing_error,
    output logic        overrun,
    output logic [2:0]  dbg_state_o
);

    localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(TICKS_PER_BIT);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF   = CW'(TICKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST   = IW'(WIDTH - 1);

    if (TICKS_PER_BIT < 4) begin : g_bad_ticks
        $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_BREAK  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ovr_q, ovr_d;
    logic             rx_meta_q, rx_s_q;
    logic             tick;
    logic             deliver;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    // The line is asynchronous; nothing downstream looks at rx directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ovr_d     = 1'b0;
        deliver   = 1'b0;
        tick      = (cnt_q == '0);
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = HALF;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s_q) begin
                    state_d = S_DATA;
                    cnt_d   = RELOAD;
                    idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
                    cnt_d   = RELOAD;
                    if (idx_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    par_err_d = rx_s_q ^ (^shift_q);
                    cnt_d     = RELOAD;
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid stop bit lets the next start edge follow a one-bit stop.
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rx_s_q) begin
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (par_err_q) fe_d = 1'b1;
                    else           deliver = 1'b1;
`else
                    deliver = 1'b1;
`endif
                end else begin
                    fe_d    = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (deliver) begin
            if (!valid_q || out_if.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign out_if.data   = data_q;
    assign out_if.valid  = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ovr_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit; a scoreboard queue holds expected words.
module tb_uart_rx;

    localparam int W   = 8;
    localparam int TPB = 16;

    logic       clock;
    logic       reset;
    logic       rx;
    logic       framing_error;
    logic       overrun;
    logic [2:0] dbg_state;

    uart_rx_if #(.WIDTH(W)) rx_if ();

    uart_rx #(.CLOCK_FREQ(1_600), .BAUD_RATE(100), .WIDTH(W)) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .out_if        (rx_if),
        .framing_error (framing_error),
        .overrun       (overrun),
        .dbg_state_o   (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q[$];

    int fe_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, vhigh_cnt = 0;
    logic         v_prev = 1'b0, r_prev = 1'b0;
    logic [W-1:0] d_prev = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic send_bit(input logic b);
        rx = b;
        repeat (TPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop_b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity");
`endif
        send_bit(stop_b);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clock);
        check("drain", exp_q.size(), 0);
    endtask

    // scoreboard / monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_if.valid && rx_if.ready) begin
                if (exp_q.size() == 0) check("unexpected_word", rx_if.data, 32'hFFFF_FFFF);
                else                   check("data", rx_if.data, exp_q.pop_front());
            end
            if (v_prev && !r_prev) begin
                check("hold_valid", rx_if.valid, 1'b1);
                check("hold_data", rx_if.data, d_prev);
            end
            fe_cnt    += int'(framing_error);
            ovr_cnt   += int'(overrun);
            vhigh_cnt += int'(rx_if.valid);
            if (rx_if.valid && !v_prev) vrise_cnt++;
            v_prev = rx_if.valid;
            r_prev = rx_if.ready;
            d_prev = rx_if.data;
        end else begin
            v_prev = 1'b0;
            r_prev = 1'b0;
        end
    end

    initial begin
        int fe0, ovr0, vr0, vh0;
        logic [W-1:0] d77, r;
        reset = 1'b1;
        rx = 1'b1;
        rx_if.ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_valid", rx_if.valid, 0);
        check("rst_data", rx_if.data, 0);
        check("rst_fe", framing_error, 0);
        check("rst_ovr", overrun, 0);
        check("rst_state", dbg_state, 0);
        reset = 1'b0;
        idle(20);

        // single frame
        fe0 = fe_cnt; ovr0 = ovr_cnt; vh0 = vhigh_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(10);
        wait_drain(200);
        check("a5_vhigh", vhigh_cnt - vh0, 1);
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ovr", ovr_cnt - ovr0, 0);

        // back-to-back with one stop bit
        vr0 = vrise_cnt;
        exp_q.push_back(8'h00); send_frame(8'h00, 1'b1, 1'b0);
        exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1, 1'b0);
        exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1, 1'b0);
        idle(10);
        wait_drain(200);
        check("b2b_count", vrise_cnt - vr0, 3);

        // glitch on the line
        fe0 = fe_cnt; vr0 = vrise_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        idle(40);
        check("glitch_valid", vrise_cnt - vr0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_state", dbg_state, 0);

        // bad stop bit, then long break
        fe0 = fe_cnt; vr0 = vrise_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (100) @(negedge clock);
        idle(40);
        check("break_fe", fe_cnt - fe0, 1);
        check("break_valid", vrise_cnt - vr0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(10);
        wait_drain(200);

        // overrun with consumer stalled
        rx_if.ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(20);
        check("ovr_valid", rx_if.valid, 1);
        check("ovr_data", rx_if.data, 8'h11);
        check("ovr_pulses", ovr_cnt - ovr0, 1);
        rx_if.ready = 1'b1;
        repeat (2) @(negedge clock);
        check("ovr_clear", rx_if.valid, 0);
        wait_drain(10);

        // reset in the middle of the last data bit of 0x77
        fe0 = fe_cnt; vr0 = vrise_cnt;
        d77 = 8'h77;
        send_bit(1'b0);
        for (int i = 0; i < W - 1; i++) send_bit(d77[i]);
        rx = d77[W-1];
        repeat (TPB / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_valid", rx_if.valid, 0);
        check("mid_rst_data", rx_if.data, 0);
        check("mid_rst_fe", framing_error, 0);
        check("mid_rst_ovr", overrun, 0);
        reset = 1'b0;
        repeat (TPB / 2 - 1) @(negedge clock);
        send_bit(1'b1);
        idle(40);
        check("mid_rst_novalid", vrise_cnt - vr0, 0);
        check("mid_rst_nofe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);
        wait_drain(200);

        // random back-to-back words
        for (int i = 0; i < 4; i++) begin
            r = W'($urandom_range(0, 255));
            exp_q.push_back(r);
            send_frame(r, 1'b1, 1'b0);
        end
        idle(10);
        wait_drain(200);

`ifdef UART_RX_PARITY_EN
        fe0 = fe_cnt; vr0 = vrise_cnt;
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(10);
        wait_drain(200);
        send_frame(8'h03, 1'b1, 1'b1);
        idle(20);
        check("par_fe", fe_cnt - fe0, 1);
        check("par_valid", vrise_cnt - vr0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
